// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping engine.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam int CNT_W = 7;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t SMS_MAX = 7'd99;
  localparam cnt_t S_MAX   = 7'd59;

  function automatic cnt_t wrap_inc(input cnt_t v, input cnt_t top);
    return (v == top) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Button inputs and time outputs of the stopwatch engine.
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic start_stop;
  logic lap;
  logic clr;
  cnt_t sms;
  cnt_t s;
  cnt_t m;
  logic running;
  logic ovf;

  modport master (output start_stop, lap, clr, input sms, s, m, running, ovf);
  modport slave  (input start_stop, lap, clr, output sms, s, m, running, ovf);
endinterface

// File: rtl/sw_btn_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module sw_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  // sh[0], sh[1]: synchronizer; sh[2]: previous synchronized level
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], btn};
  end

  assign pulse = sh[1] & ~sh[2];
endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping engine: 100 Hz prescaler, cs/s/m cascade, run-control FSM.
// Optional lap freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core #(
  parameter int TICK_DIV = 500000,
  parameter int M_MAX    = 99
) (
  input logic        clk,
  input logic        rst_n,
  stopwatch_if.slave bus
);
  import stopwatch_pkg::*;

  localparam int            PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM  = PW'(TICK_DIV - 1);
  localparam cnt_t          M_TOP = cnt_t'(M_MAX);

  // Asynchronous assert, synchronous release
  logic [1:0] rst_sync;
  logic       arst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign arst_n = rst_sync[1];

  logic ss_p, lap_p, clr_p;

  sw_btn_edge u_ss  (.clk(clk), .rst_n(arst_n), .btn(bus.start_stop), .pulse(ss_p));
  sw_btn_edge u_lap (.clk(clk), .rst_n(arst_n), .btn(bus.lap),        .pulse(lap_p));
  sw_btn_edge u_clr (.clk(clk), .rst_n(arst_n), .btn(bus.clr),        .pulse(clr_p));

  sw_state_t state_q, state_d;
  logic      clear, presc_clr;
`ifdef STOPWATCH_LAP_EN
  logic      frz_tgl, frz_rel;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Priority: clr, then start_stop, then lap
  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    presc_clr = 1'b0;
`ifdef STOPWATCH_LAP_EN
    frz_tgl   = 1'b0;
    frz_rel   = 1'b0;
`endif
    if (clr_p) begin
      state_d = IDLE;
      clear   = 1'b1;
    end else if (ss_p) begin
      case (state_q)
        IDLE: begin
          state_d   = RUN;
          presc_clr = 1'b1;
        end
        RUN: begin
          state_d = PAUSE;
`ifdef STOPWATCH_LAP_EN
          frz_rel = 1'b1;
`endif
        end
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (lap_p) begin
      if (state_q == PAUSE) begin
        state_d = IDLE;
        clear   = 1'b1;
      end
`ifdef STOPWATCH_LAP_EN
      else if (state_q == RUN) begin
        frz_tgl = 1'b1;
      end
`endif
    end
  end

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (state_q == RUN) && (presc == TERM);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                presc <= '0;
    else if (clear || presc_clr) presc <= '0;
    else if (state_q == RUN)    presc <= tick ? '0 : presc + 1'b1;
  end

  cnt_t sms_q, s_q, m_q;
  cnt_t sms_d, s_d, m_d;
  logic ovf_q, wrap;

  // Whole cascade resolves combinationally so all digits move on the same edge
  always_comb begin
    sms_d = sms_q;
    s_d   = s_q;
    m_d   = m_q;
    wrap  = 1'b0;
    if (tick) begin
      sms_d = wrap_inc(sms_q, SMS_MAX);
      if (sms_q == SMS_MAX) begin
        s_d = wrap_inc(s_q, S_MAX);
        if (s_q == S_MAX) begin
          m_d  = wrap_inc(m_q, M_TOP);
          wrap = (m_q == M_TOP);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sms_q <= '0;
      s_q   <= '0;
      m_q   <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      sms_q <= '0;
      s_q   <= '0;
      m_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      sms_q <= sms_d;
      s_q   <= s_d;
      m_q   <= m_d;
      if (wrap) ovf_q <= 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic frozen_q;
  cnt_t snap_sms, snap_s, snap_m;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                frozen_q <= 1'b0;
    else if (clear || frz_rel) frozen_q <= 1'b0;
    else if (frz_tgl)          frozen_q <= ~frozen_q;
  end

  // Snapshot takes next-state counts so a same-cycle tick is included
  always_ff @(posedge clk) begin
    if (frz_tgl && !frozen_q) begin
      snap_sms <= sms_d;
      snap_s   <= s_d;
      snap_m   <= m_d;
    end
  end

  assign bus.sms = frozen_q ? snap_sms : sms_q;
  assign bus.s   = frozen_q ? snap_s   : s_q;
  assign bus.m   = frozen_q ? snap_m   : m_q;
`else
  assign bus.sms = sms_q;
  assign bus.s   = s_q;
  assign bus.m   = m_q;
`endif

  assign bus.running = (state_q == RUN);
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed scoreboard bench for stopwatch_core with TICK_DIV=4, M_MAX=2.
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  localparam int TD      = 4;
  localparam int MM      = 2;
  localparam int WRAP_CS = (MM + 1) * 6000;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  stopwatch_if bus ();

  stopwatch_core #(.TICK_DIV(TD), .M_MAX(MM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [22:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Behavioural reference: elapsed centiseconds, prescaler phase, run state
  int cs   = 0;
  int ph   = 0;
  int st   = 0;
  int snap = 0;
  bit frz  = 1'b0;

  function automatic logic [22:0] exp_vec();
    int         d;
    logic [6:0] a, b, c;
    d = frz ? snap : cs;
    a = 7'(d % 100);
    b = 7'((d / 100) % 60);
    c = 7'((d / 6000) % (MM + 1));
    return {a, b, c, (st == 1), (cs >= WRAP_CS)};
  endfunction

  task automatic adv(input int n);
    if (st == 1) begin
      ph = ph + n;
      cs = cs + ph / TD;
      ph = ph % TD;
    end
  endtask

  task automatic clear_model();
    cs  = 0;
    ph  = 0;
    st  = 0;
    frz = 1'b0;
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag;
    e.v   = exp_vec();
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t        e;
    logic [22:0] act;
    e   = sb.pop_front();
    act = {bus.sms, bus.s, bus.m, bus.running, bus.ovf};
    vectors++;
    assert (act === e.v) else begin
      miscompares++;
      $error("FAIL %s: got m/s/sms=%0d/%0d/%0d run=%b ovf=%b, expected %0d/%0d/%0d run=%b ovf=%b",
             e.tag, act[8:2], act[15:9], act[22:16], act[1], act[0],
             e.v[8:2], e.v[15:9], e.v[22:16], e.v[1], e.v[0]);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_chk(input int n, input string tag);
    adv(n);
    push(tag);
    cyc(n);
    pop_cmp();
  endtask

  // Button press: effect is visible 3 clk after the rising pin edge
  task automatic press(input bit b_ss, input bit b_lap, input bit b_clr, input string tag);
    adv(3);
    if (b_clr) begin
      clear_model();
    end else if (b_ss) begin
      case (st)
        0:       begin st = 1; ph = 0; end
        1:       begin st = 2; frz = 1'b0; end
        default: st = 1;
      endcase
    end else if (b_lap) begin
      if (st == 2) clear_model();
      else if (st == 1 && LAP_EN) begin
        frz  = !frz;
        snap = cs;
      end
    end
    push(tag);
    bus.start_stop = b_ss;
    bus.lap        = b_lap;
    bus.clr        = b_clr;
    cyc(3);
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clr        = 1'b0;
    pop_cmp();
    adv(2);
    cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clr        = 1'b0;
    cyc(3);
    push("reset");
    pop_cmp();

    rst_n = 1'b1;
    run_chk(6, "idle_after_reset");
    press(1'b0, 1'b1, 1'b0, "lap_in_idle");
    press(1'b1, 1'b0, 1'b0, "start");
    run_chk(398, "one_second");
    run_chk(23596, "pre_minute");
    run_chk(3, "hold_59_99");
    run_chk(1, "minute_carry");
    run_chk(47996, "pre_wrap");
    run_chk(4, "minute_wrap_ovf");
    run_chk(40, "ovf_sticky");

    run_chk(106, "pre_pause");
    press(1'b1, 1'b0, 1'b0, "pause_at_37");
    run_chk(40, "pause_hold");
    press(1'b1, 1'b0, 1'b0, "resume");
    run_chk(1, "resume_phase_tick");

    press(1'b0, 1'b0, 1'b1, "clr_in_run");
    press(1'b1, 1'b0, 1'b0, "start2");
    run_chk(835, "pre_lap");
    press(1'b0, 1'b1, 1'b0, "lap_first");
    run_chk(78, "lap_hold");
    press(1'b0, 1'b1, 1'b0, "lap_second");
    press(1'b1, 1'b1, 1'b0, "ss_lap_collide");
`ifdef STOPWATCH_LAP_EN
    press(1'b1, 1'b0, 1'b0, "resume2");
    press(1'b0, 1'b1, 1'b0, "lap_third");
    run_chk(40, "lap_hold2");
    press(1'b1, 1'b0, 1'b0, "pause_releases_freeze");
`endif
    press(1'b0, 1'b1, 1'b0, "lap_in_pause_clears");

    press(1'b1, 1'b0, 1'b0, "start3");
    run_chk(50, "run_before_reset");
    rst_n = 1'b0;
    #2;
    clear_model();
    push("async_reset");
    pop_cmp();
    cyc(2);
    rst_n = 1'b1;
    run_chk(8, "idle_after_reset2");
    press(1'b1, 1'b0, 1'b0, "start4");
    run_chk(6, "count_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping engine that produces the centisecond, second and minute values consumed by the stopwatch display converter. Divides the system clock to a 100 Hz tick, runs a cascaded 0–99 / 0–59 / 0–M_MAX counter chain, and interprets start/stop, lap and clear buttons through a small run-control state machine. Its three 7-bit binary outputs feed the display stage directly, which handles all digit conversion.

## Interface
- TICK_DIV, 500000: clock cycles per centisecond tick; 500000 gives 100 Hz from a 50 MHz clock; must be ≥2.
- M_MAX, 99: terminal value of the minute counter; must be ≤99.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_stop  in  1  debounced button level, asynchronous to clk; a rising edge toggles run/pause.
- lap  in  1  debounced button level, asynchronous; a rising edge performs the lap or clear action.
- clr  in  1  debounced level, asynchronous; a rising edge forces IDLE.
- sms  out  7  displayed centiseconds, 0–99.
- s  out  7  displayed seconds, 0–59.
- m  out  7  displayed minutes, 0–M_MAX.
- running  out  1  high in RUN.
- ovf  out  1  sticky flag, set when m wraps from M_MAX to 0.

## Operation
- Each button goes through a 2-flop synchronizer, then a registered rising-edge detect that produces a one-cycle pulse.
- States are IDLE, RUN and PAUSE.
- Transitions:
  - IDLE: start_stop → RUN; the prescaler clears to 0.
  - RUN: start_stop → PAUSE.
  - PAUSE: start_stop → RUN; the prescaler resumes from its held value.
  - PAUSE: lap → IDLE; the counters, ovf and the lap freeze all clear.
  - Any state: clr → IDLE with the same clearing.
  - IDLE: lap is ignored.
- Prescaler: counts 0..TICK_DIV-1 only in RUN and emits a tick on the terminal count.
- Counter cascade:
  - The tick increments the centisecond counter.
  - 99→0 carries into the second counter.
  - 59→0 carries into the minute counter.
  - M_MAX→0 sets ovf.
  - Counting continues after the wrap.
- Lap freeze (macro-dependent): in RUN, a lap pulse toggles freeze.
  - While frozen, sms/s/m hold the snapshot taken at the pulse and the live counters keep running.
  - A second lap pulse releases the freeze.
  - A start_stop pulse that enters PAUSE also releases the freeze, so the stopped time is shown.
- Priority within one cycle: clr first, then start_stop, then lap. A lap pulse arriving in the same cycle as a higher-priority pulse is dropped.
- A tick in the same cycle as a stop pulse is counted, then the state moves to PAUSE.
- Reset: every output is 0, the state is IDLE, the prescaler is 0 and freeze is off.

## Timing
- Button effect: a rising edge on a pin is reflected in running/outputs 3 clk later (2 sync stages + edge register). Pulses closer together than 3 clk may merge.
- Counter latency:
  - sms updates 1 clk after the tick cycle.
  - The full cascade (sms, s, m together) updates in the same cycle; there is no ripple delay across cycles.
- When not frozen, outputs are registered live counter values.
- The snapshot is captured on the cycle the lap pulse is processed; it includes any tick from that same cycle.
- rst_n asserting mid-count clears everything immediately (asynchronously). Deassertion is synchronous to clk through the design's reset synchronizer.

## Configuration
- STOPWATCH_LAP_EN defined: lap freeze is implemented as described above.
- STOPWATCH_LAP_EN undefined:
  - There are no snapshot registers and outputs are always the live counters.
  - lap in RUN is ignored.
  - lap in PAUSE still clears to IDLE.

## Structure
- Package stopwatch_pkg holds:
  - the state enum (IDLE, RUN, PAUSE);
  - the constants SMS_MAX=99 and S_MAX=59;
  - the 7-bit count type.
- One sub-module, sw_btn_edge: synchronizer plus rising-edge pulse, instantiated three times.
- The counter cascade, prescaler and FSM stay inline in stopwatch_core.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then start_stop pulse, then 400 clk → running=1, sms=100 ticks wrapped: s=1, sms=0, m=0.
- Run to m=0, s=59, sms=99, then one tick → s=0, sms=0, m=1 in the same cycle. At m=M_MAX=2, s=59, sms=99 plus one tick → m=0 and ovf=1, which stays set.
- Run, then start_stop at sms=37 → PAUSE with outputs frozen at 37. Idle 40 clk → unchanged. start_stop → resumes at 37 with the prescaler phase preserved (first tick comes after the remaining prescaler count).
- LAP_EN: lap in RUN at s=2, sms=10, then 80 clk → outputs still 2/10 while the live count advances. Second lap → outputs jump to the live value (2/30).
- PAUSE then lap → IDLE, all outputs 0, ovf=0. clr during RUN → IDLE, 0s, running=0 3 clk after the edge. start_stop and lap rising together in RUN → PAUSE only, freeze not toggled.
- rst_n low mid-RUN → all outputs 0 asynchronously; after release, start_stop is required before counting.
